data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port arbiter and access sequencer for the 32-entry, 8-bit data memory. Shares the single memory port between port 0 (CPU load/store stage) and port 1 (debug/loader port) with round-robin fairness. Drives the memory's address, read, write and write-data lines, then returns read data with a one-cycle acknowledge. Sits between the execute stage and the data memory.

## Interface
- ADDR_W, 8, address width of requests and memory port
- DATA_W, 8, data width
- DEPTH, 32, number of implemented memory words; addresses >= DEPTH are out of range
- RD_LAT, 1, cycles from mem_read asserted to mem_rdata valid (1..3)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req0, req1  in  1  access request, held until ack
- we0, we1  in  1  1 = write, 0 = read; stable while req high
- addr0, addr1  in  ADDR_W  word address; stable while req high
- wdata0, wdata1  in  DATA_W  write data; stable while req high
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  valid with ack; 1 = address out of range
- rdata0, rdata1  out  DATA_W  read data, valid with ack (0 on write/err)
- mem_addr  out  ADDR_W  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port currently owning the memory (valid when busy)

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req, select winner; latch addr, we, wdata, grant_id. In range -> ISSUE; out of range -> DONE with err, no memory strobe.
- Arbitration: only one req -> that port; both -> port other than last granted. last_grant resets to 1, so port 0 wins the first tie.
- ISSUE (1 cycle): mem_addr = latched addr; mem_write = we, mem_wdata = wdata; mem_read = !we. Write -> DONE; read -> WAIT.
- WAIT: count RD_LAT cycles; in last WAIT cycle capture mem_rdata -> DONE.
- DONE (1 cycle): ack/err/rdata of grant_id driven, other port's outputs 0; last_grant <= grant_id; -> IDLE.
- Outside ISSUE: mem_read = mem_write = 0; mem_addr, mem_wdata hold last value.
- Requester keeping req high in the cycle after ack is a new request.
- Request inputs changing while req high: undefined; not checked.
- Reset mid-operation: state -> IDLE, access abandoned, no ack; still-high req re-arbitrated after reset release.
- Reset values: all ack/err/rdata 0, mem_* 0, busy 0, grant_id 0, last_grant 1, WAIT counter 0.

## Timing
- All outputs registered.
- req sampled at edge 1 -> ISSUE cycle 1.
- Write: ack in cycle 2; 3 cycles per access including IDLE.
- Read: ack in cycle 2 + RD_LAT.
- Out of range: ack + err in cycle 1.
- Both ports continuously requesting: grants strictly alternate, no starvation.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE), port-id type, default DEPTH/RD_LAT constants.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req0, req1 and last_grant; no state.
- Top: FSM, latch registers, WAIT counter, output registers.

## Test plan
- Reset, req0 write addr 5 data 0xA5 -> mem_write=1 addr 5 in cycle 1, ack0 cycle 2, err0=0; req0 read addr 5 -> rdata0=0xA5, ack0 at cycle 2+RD_LAT.
- req0 and req1 raised same cycle, reads of addr 1 and 17 -> port 0 served first (rdata 0x01), then port 1 (rdata 0xFF in memory init); grants alternate over 8 back-to-back requests each.
- req1 alone, write addr 0x20 (DEPTH=32) -> ack1=1, err1=1 in cycle 1, no mem_write, memory unchanged.
- RD_LAT=3 build: read addr 3 -> mem_read single cycle, ack at cycle 5, rdata=0x03.
- reset low during WAIT of a port-1 read -> all outputs 0 asynchronously, no ack1; after release with req1 held -> access reissued, ack1 with correct data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state, port-id types and default geometry for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef logic port_id_t;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_RD_LAT = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick favouring the port not granted last
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_grant,
  output logic     valid,
  output port_id_t pick
);
  assign valid = req0 | req1;
  assign pick  = (req0 && req1) ? !last_grant : req1;
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one data memory port between two requesters with round-robin fairness
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);
  state_t            state, state_nx;
  port_id_t          last_grant, pick, gid_nx;
  logic              any_req, sel_we, oor, last_wait, done_nx, from_idle;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rdata_nx;
  logic [1:0]        cnt;

  rr_arbiter2 u_arb (.req0, .req1, .last_grant, .valid(any_req), .pick);

  assign sel_we    = pick ? we1 : we0;
  assign sel_addr  = pick ? addr1 : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign oor       = 32'(sel_addr) >= DEPTH;
  assign last_wait = cnt == 2'(RD_LAT - 1);
  assign from_idle = state == IDLE;
  assign gid_nx    = from_idle ? pick : grant_id;
  assign done_nx   = state_nx == DONE;
  assign rdata_nx  = state == WAIT ? mem_rdata : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = !any_req ? IDLE : oor ? DONE : ISSUE;
      ISSUE: state_nx = mem_write ? DONE : WAIT;
      WAIT:  state_nx = last_wait ? DONE : WAIT;
      DONE:  state_nx = IDLE;
    endcase
  end

  // Every output is loaded from next-state decode so it is valid in the cycle the state is entered.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state     <= state_nx;
      busy      <= state_nx != IDLE;
      cnt       <= (state == WAIT && !last_wait) ? cnt + 2'd1 : 2'd0;
      mem_read  <= state_nx == ISSUE && !sel_we;
      mem_write <= state_nx == ISSUE && sel_we;
      if (from_idle && any_req) grant_id <= pick;
      if (state_nx == ISSUE) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (state == DONE) last_grant <= grant_id;
      ack0   <= done_nx && !gid_nx;
      ack1   <= done_nx && gid_nx;
      err0   <= done_nx && !gid_nx && from_idle;
      err1   <= done_nx && gid_nx && from_idle;
      rdata0 <= (done_nx && !gid_nx) ? rdata_nx : '0;
      rdata1 <= (done_nx && gid_nx) ? rdata_nx : '0;
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed vectors and corner sequences against a behavioural memory
module tb_data_memory_arbiter;
  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0, init_mem = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, err0, err1, mem_read, mem_write, busy, grant_id;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [32];

  logic q_req = 1'b0;
  logic [7:0] q_addr = '0;
  logic q_ack0, q_ack1, q_err0, q_err1, q_mem_read, q_mem_write, q_busy, q_grant;
  logic [7:0] q_rdata0, q_rdata1, q_mem_addr, q_mem_wdata, q_mem_rdata, q_p1, q_p2;

  int pass_cnt = 0, total = 0;
  vec_t vecs [10];

  always #5 clk = ~clk;

  data_memory_arbiter u_dut (
    .clk, .reset, .req0, .req1, .we0, .we1, .addr0, .addr1, .wdata0, .wdata1,
    .ack0, .ack1, .err0, .err1, .rdata0, .rdata1, .mem_addr, .mem_read,
    .mem_write, .mem_wdata, .mem_rdata, .busy, .grant_id
  );

  data_memory_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk, .reset, .req0(q_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(q_addr), .addr1(8'h00), .wdata0(8'h00), .wdata1(8'h00),
    .ack0(q_ack0), .ack1(q_ack1), .err0(q_err0), .err1(q_err1),
    .rdata0(q_rdata0), .rdata1(q_rdata1), .mem_addr(q_mem_addr),
    .mem_read(q_mem_read), .mem_write(q_mem_write), .mem_wdata(q_mem_wdata),
    .mem_rdata(q_mem_rdata), .busy(q_busy), .grant_id(q_grant)
  );

  // Address is truncated to 5 bits so a stray out-of-range write would alias onto a low word.
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 32; i++) mem[i] <= i < 16 ? 8'(i) : 8'hFF;
    else if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_addr[4:0]] : 8'h00;
  end

  always @(posedge clk) begin
    q_p1        <= q_mem_read ? (q_mem_addr < 16 ? q_mem_addr : 8'hFF) : 8'h00;
    q_p2        <= q_p1;
    q_mem_rdata <= q_p2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ack(input logic port, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(port ? ack1 : ack0) && cyc < 30);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, nw, nr, other;
    logic got;
    logic [7:0] saddr;
    if (v.port) begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    cyc = 0; nw = 0; nr = 0; other = 0; got = 1'b0; saddr = '0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_write) nw++;
      if (mem_read) nr++;
      if (mem_write || mem_read) saddr = mem_addr;
      if (v.port ? ack0 : ack1) other++;
      got = v.port ? ack1 : ack0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(v.lat));
    chk($sformatf("v%0d_err", idx), 32'(v.port ? err1 : err0), 32'(v.err));
    chk($sformatf("v%0d_rdata", idx), 32'(v.port ? rdata1 : rdata0), 32'(v.rdata));
    chk($sformatf("v%0d_other_ack", idx), 32'(other), 32'd0);
    chk($sformatf("v%0d_writes", idx), 32'(nw), 32'(v.we && !v.err));
    chk($sformatf("v%0d_reads", idx), 32'(nr), 32'(!v.we && !v.err));
    chk($sformatf("v%0d_mem_addr", idx), 32'(saddr), v.err ? 32'd0 : 32'(v.addr));
    @(negedge clk);
  endtask

  initial begin
    int c, nr, rdc;
    vecs = '{
      '{1'b0, 1'b1, 8'h05, 8'hA5, 2, 1'b0, 8'h00},
      '{1'b0, 1'b0, 8'h05, 8'h00, 3, 1'b0, 8'hA5},
      '{1'b1, 1'b1, 8'h20, 8'h5A, 1, 1'b1, 8'h00},
      '{1'b1, 1'b0, 8'h00, 8'h00, 3, 1'b0, 8'h00},
      '{1'b1, 1'b1, 8'h14, 8'h3C, 2, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h14, 8'h00, 3, 1'b0, 8'h3C},
      '{1'b0, 1'b0, 8'h1F, 8'h00, 3, 1'b0, 8'hFF},
      '{1'b0, 1'b0, 8'hFF, 8'h00, 1, 1'b1, 8'h00},
      '{1'b1, 1'b0, 8'h20, 8'h00, 1, 1'b1, 8'h00},
      '{1'b0, 1'b0, 8'h01, 8'h00, 3, 1'b0, 8'h01}
    };
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    chk("reset_ctrl", 32'({ack0, ack1, err0, err1, busy, grant_id, mem_read, mem_write}), 32'd0);
    chk("reset_bus", {rdata0, rdata1, mem_addr, mem_wdata}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // First tie after reset must go to port 0.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd17;
    wait_ack(1'b0, c);
    chk("tie_p0_lat", 32'(c), 32'd3);
    chk("tie_p0_rdata", 32'(rdata0), 32'h01);
    chk("tie_p0_no_ack1", 32'(ack1), 32'd0);
    req0 = 1'b0;
    wait_ack(1'b1, c);
    chk("tie_p1_lat", 32'(c), 32'd4);
    chk("tie_p1_rdata", 32'(rdata1), 32'hFF);
    req1 = 1'b0;
    @(negedge clk);

    req0 = 1'b1; addr0 = 8'd2;
    req1 = 1'b1; addr1 = 8'd4;
    for (int i = 0; i < 16; i++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!(ack0 || ack1) && c < 10);
      chk($sformatf("alt%0d_port", i), 32'(ack1), 32'(i % 2));
      chk($sformatf("alt%0d_gap", i), 32'(c), i == 0 ? 32'd3 : 32'd4);
      chk($sformatf("alt%0d_grant", i), 32'(grant_id), 32'(i % 2));
      chk($sformatf("alt%0d_rdata", i), 32'(ack1 ? rdata1 : rdata0), (i % 2) ? 32'd4 : 32'd2);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

    // Abort a port-1 read in WAIT, then let the held request replay.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h14;
    @(negedge clk);
    chk("rst_issue_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("rst_wait_busy", 32'({busy, grant_id}), 32'd3);
    reset = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({ack0, ack1, err0, err1, busy, grant_id, mem_read, mem_write}), 32'd0);
    chk("rst_async_bus", {rdata0, rdata1, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_held_no_ack", 32'({ack0, ack1, busy}), 32'd0);
    reset = 1'b1;
    wait_ack(1'b1, c);
    chk("rst_replay_lat", 32'(c), 32'd3);
    chk("rst_replay_rdata", 32'(rdata1), 32'h3C);
    req1 = 1'b0;
    @(negedge clk);

    q_req = 1'b1; q_addr = 8'd3;
    c = 0; nr = 0; rdc = 0;
    do begin
      @(negedge clk);
      c++;
      if (q_mem_read) begin nr++; rdc = c; end
    end while (!q_ack0 && c < 20);
    q_req = 1'b0;
    chk("lat3_ack_cycle", 32'(c), 32'd5);
    chk("lat3_read_count", 32'(nr), 32'd1);
    chk("lat3_read_cycle", 32'(rdc), 32'd1);
    chk("lat3_rdata", 32'(q_rdata0), 32'h03);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
